// File: rtl/decoder_sequencer_pkg.sv
// decoder_sequencer_pkg: shared states, protocol numbers and abort length for the decoder sequencer
package decoder_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, FEED, WAIT, ABORT} state_t;
    localparam logic [7:0] PROTO_TCP = 8'd6;
    localparam logic [7:0] PROTO_UDP = 8'd17;
    localparam int ABORT_LEN = 2;
endpackage

// File: rtl/decoder_sequencer_sat_counter.sv
// sat_counter: statistics counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk)
        count <= clr ? '0 : (inc && !(&count)) ? count + 1'b1 : count;
endmodule

// File: rtl/decoder_sequencer.sv
// decoder_sequencer: feeds frame-buffer packets to the IP/TCP/UDP decoder and tracks the outcome
// Statistics counters are built only when DECODER_SEQ_STATS_EN is defined; otherwise they read 0.
module decoder_sequencer
    import decoder_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic             in_ready,
    output logic [31:0]      dec_data,
    output logic             dec_start,
    output logic             dec_reset,
    input  logic             dec_ok,
    input  logic             dec_fin,
    input  logic [7:0]       dec_protocol,
    output logic             pkt_done,
    output logic             pkt_ok,
    output logic [CNT_W-1:0] tcp_cnt,
    output logic [CNT_W-1:0] udp_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int TW = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] A_LAST = TW'(ABORT_LEN - 1);

    state_t        state, state_next;
    logic [TW-1:0] timer;
    logic          go, feed_ok, done_wait, done_abort;
    logic          tcp_inc, udp_inc, err_inc, drop_inc;

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = go ? (in_eop ? WAIT : FEED) : IDLE;
            FEED:    state_next = (dec_fin || !in_valid || in_sop) ? ABORT : in_eop ? WAIT : FEED;
            WAIT:    state_next = dec_fin ? IDLE : (timer == T_LAST) ? ABORT : WAIT;
            ABORT:   state_next = (timer == A_LAST) ? IDLE : ABORT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = state == IDLE || state == FEED;
        dec_reset  = reset || state == ABORT;
        go         = state == IDLE && in_valid && in_sop;
        drop_inc   = state == IDLE && in_valid && !in_sop;
        feed_ok    = state == FEED && in_valid && !in_sop;
        done_wait  = state == WAIT && dec_fin;
        done_abort = state == ABORT && timer == A_LAST;
        tcp_inc    = done_wait && dec_ok && dec_protocol == PROTO_TCP;
        udp_inc    = done_wait && dec_ok && dec_protocol == PROTO_UDP;
        err_inc    = (done_wait && !dec_ok) || done_abort;
    end

    // One timer serves both the WAIT timeout and the ABORT length: it restarts on every state change.
    always_ff @(posedge clk)
        timer <= (reset || state_next != state) ? '0 : timer + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_data  <= '0;
            dec_start <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_ok    <= 1'b0;
        end else begin
            dec_start <= go;
            pkt_done  <= done_wait || done_abort;
            if (go || feed_ok)
                dec_data <= in_data;
            if (done_wait)
                pkt_ok <= dec_ok;
            else if (done_abort)
                pkt_ok <= 1'b0;
        end
    end

`ifdef DECODER_SEQ_STATS_EN
    sat_counter #(.CNT_W(CNT_W)) u_tcp  (.clk(clk), .clr(reset), .inc(tcp_inc),  .count(tcp_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_udp  (.clk(clk), .clr(reset), .inc(udp_inc),  .count(udp_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_err  (.clk(clk), .clr(reset), .inc(err_inc),  .count(err_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_drop (.clk(clk), .clr(reset), .inc(drop_inc), .count(drop_cnt));
`else
    logic unused_stats;
    assign unused_stats = &{1'b0, tcp_inc, udp_inc, err_inc, drop_inc};
    assign tcp_cnt  = '0;
    assign udp_cnt  = '0;
    assign err_cnt  = '0;
    assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_decoder_sequencer.sv
// tb_decoder_sequencer: directed and random stimulus checked every cycle against a packet-level model
module tb_decoder_sequencer;
    localparam int T = 8;
    localparam int W = 4;
    localparam int CMAX = (1 << W) - 1;
    localparam bit STATS = `ifdef DECODER_SEQ_STATS_EN 1'b1 `else 1'b0 `endif;

    logic clk = 1'b0, reset = 1'b1;
    logic [31:0] in_data = '0;
    logic in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
    logic dec_ok = 1'b0, dec_fin = 1'b0;
    logic [7:0] dec_protocol = '0;
    logic in_ready, dec_start, dec_reset, pkt_done, pkt_ok;
    logic [31:0] dec_data;
    logic [W-1:0] tcp_cnt, udp_cnt, err_cnt, drop_cnt;

    always #5 clk = ~clk;

    decoder_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(W)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
        .in_eop(in_eop), .in_ready(in_ready), .dec_data(dec_data), .dec_start(dec_start),
        .dec_reset(dec_reset), .dec_ok(dec_ok), .dec_fin(dec_fin), .dec_protocol(dec_protocol),
        .pkt_done(pkt_done), .pkt_ok(pkt_ok), .tcp_cnt(tcp_cnt), .udp_cnt(udp_cnt),
        .err_cnt(err_cnt), .drop_cnt(drop_cnt)
    );

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 0;
    int start_seen = 0, done_seen = 0, rst_seen = 0;

    // Packet-level reference: phase 0 idle, 1 streaming words, 2 awaiting verdict, 3 aborting
    int phase = 0, waited = 0, abort_cycles = 0;
    logic [31:0] e_data = '0;
    logic e_start = 0, e_done = 0, e_ok = 0;
    int c_tcp = 0, c_udp = 0, c_err = 0, c_drop = 0;

    function automatic int sat(input int c);
        return c < CMAX ? c + 1 : c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            phase = 0; e_data = '0; e_start = 0; e_done = 0; e_ok = 0;
            c_tcp = 0; c_udp = 0; c_err = 0; c_drop = 0;
        end else begin
            e_start = 0;
            e_done = 0;
            if (phase == 0) begin
                if (in_valid && in_sop) begin
                    e_data = in_data; e_start = 1; waited = 0;
                    phase = in_eop ? 2 : 1;
                end else if (in_valid) c_drop = sat(c_drop);
            end else if (phase == 1) begin
                if (in_valid && !in_sop) e_data = in_data;
                if (dec_fin || !in_valid || in_sop) begin phase = 3; abort_cycles = 0; end
                else if (in_eop) begin phase = 2; waited = 0; end
            end else if (phase == 2) begin
                if (dec_fin) begin
                    e_done = 1; e_ok = dec_ok; phase = 0;
                    if (!dec_ok) c_err = sat(c_err);
                    else if (dec_protocol == 8'd6) c_tcp = sat(c_tcp);
                    else if (dec_protocol == 8'd17) c_udp = sat(c_udp);
                end else if (waited + 1 == T) begin phase = 3; abort_cycles = 0; end
                else waited++;
            end else begin
                abort_cycles++;
                if (abort_cycles == 2) begin
                    e_done = 1; e_ok = 0; phase = 0; c_err = sat(c_err);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, phase < 2);
            chk("dec_reset", dec_reset, reset || phase == 3);
            chk("dec_data", dec_data, e_data);
            chk("dec_start", dec_start, e_start);
            chk("pkt_done", pkt_done, e_done);
            chk("pkt_ok", pkt_ok, e_ok);
            chk("tcp_cnt", tcp_cnt, STATS ? c_tcp : 0);
            chk("udp_cnt", udp_cnt, STATS ? c_udp : 0);
            chk("err_cnt", err_cnt, STATS ? c_err : 0);
            chk("drop_cnt", drop_cnt, STATS ? c_drop : 0);
        end
        if (dec_start) start_seen++;
        if (pkt_done) done_seen++;
        if (dec_reset && !reset) rst_seen++;
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic quiet();
        in_valid = 0; in_sop = 0; in_eop = 0; in_data = '0; dec_fin = 0; dec_ok = 0; dec_protocol = '0;
    endtask

    task automatic word(input logic [31:0] d, input logic s, input logic e);
        in_valid = 1; in_data = d; in_sop = s; in_eop = e;
        cyc();
    endtask

    task automatic fin(input logic ok, input logic [7:0] p);
        quiet();
        dec_fin = 1; dec_ok = ok; dec_protocol = p;
        cyc();
        quiet();
    endtask

    task automatic clear_mon();
        start_seen = 0; done_seen = 0; rst_seen = 0;
    endtask

    task automatic pkt5_tcp(input logic [31:0] base);
        for (int i = 0; i < 5; i++) word(base + 32'(i), i == 0, i == 4);
        quiet();
        @(negedge clk);
        chk("lit_last_word", dec_data, base + 32'd4);
        chk("lit_wait_ready", in_ready, 1'b0);
        cyc(2);
        fin(1'b1, 8'd6);
        cyc();
    endtask

    initial begin
        cyc();
        chk_en = 1;
        cyc(2);
        @(negedge clk);
        chk("lit_reset_decrst", dec_reset, 1'b1);
        chk("lit_reset_data", dec_data, 32'h0);
        cyc();
        reset = 0;
        cyc();
        @(negedge clk);
        chk("lit_after_reset_decrst", dec_reset, 1'b0);
        chk("lit_after_reset_ready", in_ready, 1'b1);
        cyc();

        clear_mon();
        pkt5_tcp(32'hA000_0000);
        chk("lit_5w_start", start_seen, 1);
        chk("lit_5w_done", done_seen, 1);
        chk("lit_5w_ok", pkt_ok, 1'b1);
        chk("lit_5w_tcp", tcp_cnt, STATS ? 1 : 0);

        word(32'hB000_0001, 1, 1);
        cyc();
        fin(1'b1, 8'd17);
        cyc();
        chk("lit_1w_udp", udp_cnt, STATS ? 1 : 0);
        chk("lit_1w_ok", pkt_ok, 1'b1);

        clear_mon();
        for (int i = 0; i < 3; i++) word(32'hC000_0000 + 32'(i), i == 0, 1'b0);
        quiet();
        cyc(4);
        chk("lit_under_rst2", rst_seen, 2);
        chk("lit_under_done", done_seen, 1);
        chk("lit_under_ok", pkt_ok, 1'b0);
        chk("lit_under_err", err_cnt, STATS ? 1 : 0);
        chk("lit_under_idle", in_ready, 1'b1);

        word(32'hD000_0000, 1, 1);
        quiet();
        cyc(7);
        @(negedge clk);
        chk("lit_to_before", dec_reset, 1'b0);
        cyc();
        @(negedge clk);
        chk("lit_to_abort", dec_reset, 1'b1);
        cyc(3);
        chk("lit_to_err", err_cnt, STATS ? 2 : 0);

        word(32'hD100_0000, 1, 1);
        quiet();
        cyc(7);
        fin(1'b1, 8'd6);
        @(negedge clk);
        chk("lit_fin8_done", pkt_done, 1'b1);
        chk("lit_fin8_ok", pkt_ok, 1'b1);
        chk("lit_fin8_norst", dec_reset, 1'b0);
        cyc();
        chk("lit_fin8_tcp", tcp_cnt, STATS ? 2 : 0);

        clear_mon();
        for (int i = 0; i < 3; i++) word(32'hE000_0000 + 32'(i), 1'b0, 1'b0);
        quiet();
        cyc();
        chk("lit_drop3", drop_cnt, STATS ? 3 : 0);
        chk("lit_drop_nostart", start_seen, 0);

        for (int i = 0; i < 3; i++) word(32'hF000_0000 + 32'(i), i == 0, 1'b0);
        in_valid = 1; in_data = 32'hF000_0003; reset = 1;
        cyc();
        @(negedge clk);
        chk("lit_midrst_data", dec_data, 32'h0);
        chk("lit_midrst_decrst", dec_reset, 1'b1);
        chk("lit_midrst_drop", drop_cnt, 0);
        cyc();
        reset = 0;
        quiet();
        cyc();
        clear_mon();
        pkt5_tcp(32'h1234_0000);
        chk("lit_post_rst_tcp", tcp_cnt, STATS ? 1 : 0);
        chk("lit_post_rst_start", start_seen, 1);

        for (int i = 0; i < 20; i++) word(32'(i), 1'b0, 1'b0);
        quiet();
        cyc();
        chk("lit_drop_sat", drop_cnt, STATS ? CMAX : 0);

        for (int i = 0; i < 3000; i++) begin
            reset = $urandom_range(0, 299) == 0;
            in_valid = $urandom_range(0, 9) < 8;
            in_sop = $urandom_range(0, 9) < 2;
            in_eop = $urandom_range(0, 9) < 3;
            in_data = $urandom;
            dec_fin = $urandom_range(0, 9) == 0;
            dec_ok = $urandom_range(0, 9) < 7;
            case ($urandom_range(0, 2))
                0: dec_protocol = 8'd6;
                1: dec_protocol = 8'd17;
                default: dec_protocol = 8'($urandom);
            endcase
            cyc();
        end
        reset = 0;
        quiet();
        cyc(12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/decoder_sequencer.md
DECODER_SEQUENCER -- requirements
Module: decoder_sequencer

Interface
- REQ-001: The module SHALL have parameter TIMEOUT_CYCLES, default 4096, giving the maximum cycles in WAIT before abort.
- REQ-002: The module SHALL have parameter CNT_W, default 16, giving the width of each statistics counter.
- REQ-003: Port clk, input, 1 bit, SHALL be the single clock; all logic is on the rising edge.
- REQ-004: Port reset, input, 1 bit, SHALL be the synchronous, active-high reset.
- REQ-005: Port in_data, input, 32 bits, SHALL carry the packet word from the frame buffer.
- REQ-006: Ports in_valid, in_sop and in_eop, inputs, 1 bit each, SHALL qualify in_data as valid, first word and last word.
- REQ-007: Port in_ready, output, 1 bit, SHALL mean the word is consumed this cycle when in_valid is also high.
- REQ-008: Ports dec_data (output, 32 bits), dec_start (output, 1 bit) and dec_reset (output, 1 bit) SHALL drive the combined IP/TCP/UDP decoder.
- REQ-009: Ports dec_ok, dec_fin (inputs, 1 bit each) and dec_protocol (input, 8 bits) SHALL be the decoder status inputs.
- REQ-010: Ports pkt_done and pkt_ok, outputs, 1 bit each, SHALL report per-packet completion and result.
- REQ-011: Ports tcp_cnt, udp_cnt, err_cnt and drop_cnt, outputs, CNT_W bits each, SHALL be the statistics counters.

Function
- REQ-012: The state machine SHALL have exactly four states: IDLE, FEED, WAIT and ABORT.
- REQ-013: in_ready SHALL be 1 in IDLE and FEED and 0 in WAIT and ABORT.
- REQ-014: In IDLE, in_valid&in_sop SHALL register dec_data=in_data and assert dec_start for exactly 1 cycle, giving 1-cycle latency.
- REQ-015: From that IDLE start, the next state SHALL be WAIT if in_eop is also high, else FEED.
- REQ-016: In IDLE, in_valid without in_sop SHALL consume and discard the word, increment drop_cnt and remain in IDLE.
- REQ-017: In FEED, each word with in_valid high SHALL be registered onto dec_data, with dec_start low; in_eop SHALL move to WAIT.
- REQ-018: In FEED, in_valid low (underrun) SHALL move to ABORT.
- REQ-019: In FEED, in_sop high (unexpected restart) SHALL consume the word and move to ABORT.
- REQ-020: In FEED, dec_fin high (early finish) SHALL move to ABORT.
- REQ-021: A timer SHALL clear on entry to WAIT and increment each cycle spent in WAIT.
- REQ-022: In WAIT, dec_fin SHALL pulse pkt_done for 1 cycle in the following cycle with pkt_ok=dec_ok, then move to IDLE.
- REQ-023: On that WAIT completion, if dec_ok=1, tcp_cnt SHALL increment when dec_protocol=6 and udp_cnt SHALL increment when dec_protocol=17.
- REQ-024: On that WAIT completion, if dec_ok=0, err_cnt SHALL increment.
- REQ-025: In WAIT, the timer reaching TIMEOUT_CYCLES-1 without dec_fin SHALL move to ABORT; dec_fin arriving in that same cycle SHALL take priority and complete normally.
- REQ-026: ABORT SHALL assert dec_reset for exactly 2 cycles, increment err_cnt once, pulse pkt_done with pkt_ok=0, and then return to IDLE.
- REQ-027: Counters SHALL saturate at all-ones and SHALL NOT wrap.
- REQ-028: pkt_ok SHALL hold its last value between pkt_done pulses.

Reset
- REQ-029: Reset SHALL take effect at the next clock edge and override every transition, including mid-packet and mid-ABORT.
- REQ-030: Reset SHALL set state=IDLE, timer=0, dec_data=0, dec_start=0, pkt_done=0, pkt_ok=0 and all counters=0.
- REQ-031: While reset is high, dec_reset SHALL be 1; dec_reset SHALL be 0 on the first cycle after reset deasserts.

Configuration
- REQ-032: With DECODER_SEQ_STATS_EN defined, the four counters SHALL be implemented as specified.
- REQ-033: Without DECODER_SEQ_STATS_EN, the counters SHALL be omitted, their outputs SHALL tie to 0, and all other behaviour SHALL be unchanged.

Structure
- REQ-034: The shared package SHALL hold the state enum, the protocol constants PROTO_TCP=8'd6 and PROTO_UDP=8'd17, and the ABORT reset length of 2.
- REQ-035: A sub-module sat_counter (CNT_W, increment enable, synchronous clear) SHALL be instantiated four times.

Verification
- REQ-036: A 5-word packet with sop on word 0 and eop on word 4, followed by dec_fin with dec_ok=1 and dec_protocol=6 -> dec_start for 1 cycle, 5 dec_data words on consecutive cycles, pkt_done with pkt_ok=1, tcp_cnt=1.
- REQ-037: A single-word packet (sop and eop together), then dec_fin with dec_ok=1 and dec_protocol=17 -> udp_cnt=1 and pkt_ok=1.
- REQ-038: in_valid dropped after word 2 of 6 -> ABORT, dec_reset high for 2 cycles, err_cnt=1, pkt_ok=0, back in IDLE.
- REQ-039: With TIMEOUT_CYCLES=8 and no dec_fin -> abort exactly 8 cycles after entering WAIT; a separate run with dec_fin on cycle 8 -> normal completion.
- REQ-040: Three words without sop in IDLE -> drop_cnt=3 and no dec_start.
- REQ-041: Reset asserted mid-FEED -> all outputs return to reset values on the next edge, and the following packet decodes normally.
